// File: rtl/data_mem.sv
// Word-organised, byte-writable data memory with one-cycle registered read,
// a post-reset clearing sweep and out-of-window access flagging.
`timescale 1ns/1ps

module data_mem #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DMEM_add_i,
    input  logic [3:0]  DMEM_byte_mark_i,
    input  logic [31:0] DMEM_data_write_i,
    output logic [31:0] DMEM_data_o,
    output logic        DMEM_busy_o,
    output logic        DMEM_err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH];

    logic [29:0]   off_word;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   merged;

    logic [3:0]    mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;

    // The requester always drives a word-aligned address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^DMEM_add_i[1:0];

    // Subtracting word addresses equals off[31:2] of the 32-bit byte subtraction
    // because BASE_ADDR is word aligned.
    assign off_word = DMEM_add_i[31:2] - BASE_ADDR[31:2];
    assign in_range = (off_word < 30'(DEPTH));
    assign idx      = off_word[AW-1:0];
    assign rd_word  = mem_q[idx];

    // Write-first read: the registered word already carries this cycle's lanes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = DMEM_byte_mark_i[k] ? DMEM_data_write_i[8*k +: 8]
                                                   : rd_word[8*k +: 8];
        end
    end

    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 4'b0000;
        mem_idx   = idx;
        mem_wdata = DMEM_data_write_i;
        data_d    = 32'h0;
        err_d     = 1'b0;

        case (state_q)
            S_INIT: begin
                mem_we    = 4'b1111;
                mem_idx   = cnt_q;
                mem_wdata = 32'h0;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_READY: begin
                if (in_range) begin
                    mem_we = DMEM_byte_mark_i;
                    data_d = merged;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    assign DMEM_data_o = data_q;
    assign DMEM_err_o  = err_q;
    assign DMEM_busy_o = (state_q == S_INIT);

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: two instances (32 words at 0, 16 words at 0x1000)
// driven by directed requests; a monitor pops expected responses and compares.
`timescale 1ns/1ps

module tb_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic [31:0] add_a, wd_a, do_a, add_b, wd_b, do_b;
    logic [3:0]  bm_a, bm_b;
    logic        busy_a, err_a, busy_b, err_b;

    data_mem #(.DEPTH(32), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .DMEM_add_i(add_a), .DMEM_byte_mark_i(bm_a), .DMEM_data_write_i(wd_a),
        .DMEM_data_o(do_a), .DMEM_busy_o(busy_a), .DMEM_err_o(err_a)
    );

    data_mem #(.DEPTH(16), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .DMEM_add_i(add_b), .DMEM_byte_mark_i(bm_b), .DMEM_data_write_i(wd_b),
        .DMEM_data_o(do_b), .DMEM_busy_o(busy_b), .DMEM_err_o(err_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic vld_a = 1'b0, vld_b = 1'b0, mon_a = 1'b0, mon_b = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: response with no expected entry", name);
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Monitor: a request issued in one cycle is answered after the next edge.
    always @(posedge clk) begin
        mon_a <= vld_a;
        mon_b <= vld_b;
    end

    always @(negedge clk) begin
        if (mon_a) begin
            if (q_a.size() == 0) fail("a_scoreboard");
            else begin
                ea = q_a.pop_front();
                check("a_data", do_a, ea.data);
                check("a_err", {31'b0, err_a}, {31'b0, ea.err});
            end
        end
        if (mon_b) begin
            if (q_b.size() == 0) fail("b_scoreboard");
            else begin
                eb = q_b.pop_front();
                check("b_data", do_b, eb.data);
                check("b_err", {31'b0, err_b}, {31'b0, eb.err});
            end
        end
    end

    task automatic req_a(input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        @(negedge clk);
        add_a = addr; bm_a = mask; wd_a = wd; vld_a = 1'b1;
        q_a.push_back('{data: ed, err: ee});
    endtask

    task automatic req_b(input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        @(negedge clk);
        add_b = addr; bm_b = mask; wd_b = wd; vld_b = 1'b1;
        q_b.push_back('{data: ed, err: ee});
    endtask

    task automatic idle_a();
        @(negedge clk);
        bm_a = 4'b0000; vld_a = 1'b0;
    endtask

    task automatic idle_b();
        @(negedge clk);
        bm_b = 4'b0000; vld_b = 1'b0;
    endtask

    task automatic sweep_a(output int cnt);
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            check("a_sweep_data", do_a, 32'h0);
            check("a_sweep_err", {31'b0, err_a}, 32'h0);
            if (!busy_a) break;
        end
    endtask

    // Requests alternate in-range and out-of-range while busy; none may act.
    task automatic sweep_b(output int cnt);
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            check("b_sweep_data", do_b, 32'h0);
            check("b_sweep_err", {31'b0, err_b}, 32'h0);
            if (!busy_b) break;
            add_b = cnt[0] ? 32'h0000_2000 : 32'h0000_1000;
            bm_b  = 4'b1111;
            wd_b  = 32'hFFFF_FFFF;
        end
        bm_b = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        add_a = 32'h0; bm_a = 4'b0; wd_a = 32'h0;
        add_b = 32'h0000_1000; bm_b = 4'b1111; wd_b = 32'hFFFF_FFFF;
        #2;
        check("a_rst_busy", {31'b0, busy_a}, 32'h1);
        check("a_rst_data", do_a, 32'h0);
        check("a_rst_err", {31'b0, err_a}, 32'h0);
        check("b_rst_busy", {31'b0, busy_b}, 32'h1);

        // Instance A: sweep, then write/read patterns and the window edge.
        @(negedge clk); rst_a_n = 1'b1;
        sweep_a(n);
        check("a_busy_edges", n, 32);

        req_a(32'h40, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        req_a(32'h40, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0);
        req_a(32'h08, 4'b1111, 32'h1122_3344, 32'h1122_3344, 1'b0);
        req_a(32'h08, 4'b0100, 32'h00AA_0000, 32'h11AA_3344, 1'b0);
        req_a(32'h08, 4'b0000, 32'h0,         32'h11AA_3344, 1'b0);
        req_a(32'h08, 4'b0011, 32'h0000_5566, 32'h11AA_5566, 1'b0);
        req_a(32'h08, 4'b0000, 32'h0,         32'h11AA_5566, 1'b0);
        req_a(32'h04, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        req_a(32'h04, 4'b1000, 32'h1200_0000, 32'h12FF_FFFF, 1'b0);
        req_a(32'h04, 4'b0000, 32'h0,         32'h12FF_FFFF, 1'b0);
        req_a(32'h7C, 4'b1111, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        req_a(32'h80, 4'b1111, 32'h1111_1111, 32'h0,         1'b1);
        req_a(32'h7C, 4'b0000, 32'h0,         32'h0BAD_F00D, 1'b0);
        req_a(32'h00, 4'b0000, 32'h0,         32'h0,         1'b0);
        idle_a();
        idle_a();

        // Instance B: sweep with ignored requests, fill, out-of-range, read-back.
        @(negedge clk); rst_b_n = 1'b1;
        sweep_b(n);
        check("b_busy_edges", n, 16);
        for (int i = 0; i < 16; i++) req_b(32'h1000 + 32'(4 * i), 4'b0000, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) req_b(32'h1000 + 32'(4 * i), 4'b1111, pat(i), pat(i), 1'b0);
        req_b(32'h0000_1040, 4'b1111, 32'hBAD0_BAD0, 32'h0, 1'b1);
        req_b(32'h0000_0FFC, 4'b1111, 32'hBAD0_BAD0, 32'h0, 1'b1);
        req_b(32'h0000_2000, 4'b0000, 32'h0,         32'h0, 1'b1);
        req_b(32'h0000_1000, 4'b0000, 32'h0,         pat(0), 1'b0);
        for (int i = 0; i < 16; i++) req_b(32'h1000 + 32'(4 * i), 4'b0000, 32'h0, pat(i), 1'b0);
        req_b(32'h0000_100C, 4'b0000, 32'h0, pat(3), 1'b0);
        idle_b();

        // Asynchronous reset while READY and holding non-zero read data.
        #1 rst_b_n = 1'b0;
        #1;
        check("b_async_busy", {31'b0, busy_b}, 32'h1);
        check("b_async_data", do_b, 32'h0);
        check("b_async_err", {31'b0, err_b}, 32'h0);

        // Reset again five edges into the sweep; the sweep must restart fully.
        @(negedge clk); rst_b_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_b_n = 1'b0;
        #1;
        check("b_mid_busy", {31'b0, busy_b}, 32'h1);
        check("b_mid_data", do_b, 32'h0);
        add_b = 32'h0000_1000; bm_b = 4'b1111; wd_b = 32'hFFFF_FFFF;
        @(negedge clk); rst_b_n = 1'b1;
        sweep_b(n);
        check("b_resweep_edges", n, 16);
        for (int i = 0; i < 16; i++) req_b(32'h1000 + 32'(4 * i), 4'b0000, 32'h0, 32'h0, 1'b0);
        idle_b();
        idle_b();

        check("a_queue_drained", q_a.size(), 32'h0);
        check("b_queue_drained", q_b.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory that responds to the MEM stage's data-memory request port. It accepts a word-aligned address, a 4-bit byte mask and lane-positioned write data every cycle. It returns the addressed word with one clock of latency, which matches the MEM stage's registered load-extraction path. After reset it runs a self-clearing sweep and reports busy until every word is zero. It also flags accesses that fall outside its address window.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- DMEM_add_i  input  32  byte address; bits [1:0] are ignored because the requester drives 0.
- DMEM_byte_mark_i  input  4  write byte enables; bit k writes lane k (bits 8k+7:8k). All-zero means no write.
- DMEM_data_write_i  input  32  write data, already shifted into its lanes.
- DMEM_data_o  output  32  registered read data for the address presented in the previous cycle.
- DMEM_busy_o  output  1  high while the clear sweep runs.
- DMEM_err_o  output  1  registered one-cycle pulse for an out-of-range access.

## Operation
- Storage: DEPTH x 32-bit array, byte-writable. The array itself is not reset; the clear sweep initialises it.
- Address decode: off = DMEM_add_i - BASE_ADDR, computed 32-bit with wrap. The access is in range when off[31:2] < DEPTH; the index is off[AW+1:2], where AW = log2(DEPTH).
- FSM states: INIT and READY.
  - rst_n low forces INIT with sweep counter cnt = 0.
  - INIT: each cycle writes 0 to word cnt and increments cnt. After writing word DEPTH-1, the next state is READY and cnt holds.
  - READY is the terminal state; only reset leaves it.
  - DMEM_busy_o = (state == INIT).
- In INIT, requester inputs are ignored: no writes, DMEM_data_o is 0, DMEM_err_o is 0.
- In READY, each cycle:
  - Write: if the address is in range and DMEM_byte_mark_i != 0, each lane with its mark bit set takes the same lane of DMEM_data_write_i. Unmarked lanes keep their value.
  - Read: DMEM_data_o <= word[index] after merging this cycle's write (write-first, per byte lane). Reads occur every cycle; there is no read enable.
  - Out of range: no array change, DMEM_data_o <= 0, DMEM_err_o <= 1 for one cycle. A write with mask 0 out of range still flags the error.
  - In range: DMEM_err_o <= 0.
- The byte-mask pattern is not checked; any of the 16 values is legal.

## Timing
- Reset values, asserted asynchronously: state = INIT, cnt = 0, DMEM_data_o = 0, DMEM_busy_o = 1, DMEM_err_o = 0.
- Clear sweep: reset releases before edge 1; edges 1..DEPTH clear words 0..DEPTH-1. DMEM_busy_o falls after edge DEPTH, and the first accepted request is sampled at edge DEPTH+1.
- Read latency: address sampled at edge N, data valid on DMEM_data_o after edge N and held until edge N+1.
- Write latency: array updated at the sampling edge. A read of the same word in the next cycle returns the new value.
- Same-cycle write and read of one word: DMEM_data_o shows the merged new word.
- Back-to-back accesses to any addresses are allowed every cycle; there are no stalls and no handshake.
- Reset asserted mid-sweep or mid-operation: outputs go to their reset values immediately and the sweep restarts from word 0. A partially cleared array is fully re-cleared.
- DMEM_err_o is aligned with DMEM_data_o and refers to the same request.

## Test plan
- Reset and sweep (DEPTH=16): release rst_n. Expect DMEM_busy_o = 1 for exactly 16 edges, then 0. Read every word afterwards and expect 32'h0; DMEM_err_o stays 0 throughout.
- Full-word write then read: mark 4'b1111, addr 0x40, data 0xDEADBEEF. Next cycle, mark 0 at addr 0x40. Expect DMEM_data_o = 0xDEADBEEF one edge later.
- Byte and half writes over 0x11223344 at 0x8:
  - mark 4'b0100 with data 0x00AA0000 → read 0x11AA3344.
  - mark 4'b0011 with data 0x00005566 → read 0x11AA5566.
- Same-cycle merge: word 0x4 holds 0xFFFFFFFF; write mark 4'b1000 with data 0x12000000. DMEM_data_o after that edge = 0x12FFFFFF.
- Out of range (BASE=0x1000, DEPTH=16): access 0x1040 and 0x0FFC with mark 4'b1111. Expect:
  - DMEM_err_o pulses 1 for each access and DMEM_data_o = 0.
  - No word changes; a full read-back of all 16 words is unchanged.
- Reset mid-sweep: assert rst_n low at sweep cycle 5 after word 0 was pre-written by backdoor. After release, busy lasts a full DEPTH cycles and all words read 0; requests presented while busy produce no write and no error.
